// File: rtl/param_buffered_router.sv
// param_buffered_router
//   Routes each accepted input word to one of N_OUT output channels chosen by
//   addr. Every channel has its own DEPTH-entry FIFO, so a slow consumer only
//   stalls input words addressed to that channel. Words whose addr is not a
//   real channel (only possible when N_OUT is not a power of two) are
//   accepted, discarded and counted in a saturating drop counter.
//
//   Ports
//     clk         in   rising-edge clock
//     reset       in   synchronous, active-high reset
//     din         in   [DATA_WIDTH]        input word
//     din_valid   in   din/addr valid
//     addr        in   [ADDR_WIDTH]        destination channel
//     din_ready   out  word accepted this cycle when din_valid is high
//     dout        out  [N_OUT*DATA_WIDTH]  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//     dout_valid  out  [N_OUT]             channel i holds a head word
//     dout_ready  in   [N_OUT]             consumer i takes its head word
//     drop_count  out  [CNT_WIDTH]         saturating count of dropped words

// Per-channel FIFO. Head word is shown only while the FIFO is non-empty;
// otherwise rdata is forced to zero.
module param_buffered_router_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  valid,
    output logic                  full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [PW:0]           count;
    logic                  pop;

    assign valid = (count != '0);
    assign full  = (count == FULL_CNT);
    assign pop   = valid & ready;
    assign rdata = valid ? mem[rptr] : '0;

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module param_buffered_router #(
    parameter int DATA_WIDTH = 32,
    parameter int N_OUT      = 4,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8,
    localparam int ADDR_WIDTH = (N_OUT > 2) ? $clog2(N_OUT) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        din_valid,
    input  logic [ADDR_WIDTH-1:0]       addr,
    output logic                        din_ready,
    output logic [N_OUT*DATA_WIDTH-1:0] dout,
    output logic [N_OUT-1:0]            dout_valid,
    input  logic [N_OUT-1:0]            dout_ready,
    output logic [CNT_WIDTH-1:0]        drop_count
);
    localparam int NPAD = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] N_OUT_W = (ADDR_WIDTH+1)'(N_OUT);

    logic [N_OUT-1:0] full;
    logic [NPAD-1:0]  full_pad;
    logic             oob;
    logic             accept;

    // Pad the full vector to the whole address space so any addr can index
    // it; phantom channels never report full and so are always accepted.
    always_comb begin
        full_pad           = '0;
        full_pad[N_OUT-1:0] = full;
    end

    assign oob       = ({1'b0, addr} >= N_OUT_W);
    // Depends only on the registered full flags, never on dout_ready.
    assign din_ready = !reset & (oob | !full_pad[addr]);
    assign accept    = din_valid & din_ready;

    always_ff @(posedge clk) begin
        if (reset)
            drop_count <= '0;
        else if (accept && oob && drop_count != '1)
            drop_count <= drop_count + 1'b1;
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_ch
        logic push;
        assign push = accept & (addr == ADDR_WIDTH'(i));

        param_buffered_router_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push),
            .wdata (din),
            .ready (dout_ready[i]),
            .rdata (dout[i*DATA_WIDTH +: DATA_WIDTH]),
            .valid (dout_valid[i]),
            .full  (full[i])
        );
    end
endmodule

// File: tb/tb_param_buffered_router.sv
module tb_param_buffered_router;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // DUT A: N_OUT=4, DEPTH=4, DATA_WIDTH=32, CNT_WIDTH=8
    logic         reset;
    logic [31:0]  din;
    logic         din_valid;
    logic [1:0]   addr;
    logic         din_ready;
    logic [127:0] dout;
    logic [3:0]   dout_valid;
    logic [3:0]   dout_ready;
    logic [7:0]   drop_count;

    param_buffered_router #(.DATA_WIDTH(32), .N_OUT(4), .DEPTH(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .addr(addr),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .drop_count(drop_count)
    );

    // DUT B: N_OUT=3 (phantom address 3), DEPTH=2, CNT_WIDTH=3
    logic        reset2;
    logic [15:0] din2;
    logic        din_valid2;
    logic [1:0]  addr2;
    logic        din_ready2;
    logic [47:0] dout2;
    logic [2:0]  dout_valid2;
    logic [2:0]  dout_ready2;
    logic [2:0]  drop_count2;

    param_buffered_router #(.DATA_WIDTH(16), .N_OUT(3), .DEPTH(2), .CNT_WIDTH(3)) dut2 (
        .clk(clk), .reset(reset2), .din(din2), .din_valid(din_valid2), .addr(addr2),
        .din_ready(din_ready2), .dout(dout2), .dout_valid(dout_valid2),
        .dout_ready(dout_ready2), .drop_count(drop_count2)
    );

    // Reference model for DUT A: one queue per channel.
    logic [31:0] q [4][$];
    bit          known = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of DUT A, check it against the model, clock it, advance
    // the model. Called and returns at a falling edge.
    task automatic cyc(input logic r, input logic v, input logic [1:0] a,
                       input logic [31:0] d, input logic [3:0] rdy);
        logic [127:0] exp_dout;
        logic [3:0]   exp_vld;
        logic         exp_rdy;
        logic [3:0]   pops;
        reset = r; din_valid = v; addr = a; din = d; dout_ready = rdy;
        #1;
        exp_rdy = !r && (q[a].size() < 4);
        chk("din_ready", 128'(din_ready), 128'(exp_rdy));
        if (known) begin
            exp_dout = '0;
            for (int i = 0; i < 4; i++) begin
                exp_vld[i] = (q[i].size() > 0);
                if (exp_vld[i]) exp_dout[i*32 +: 32] = q[i][0];
            end
            chk("dout_valid", 128'(dout_valid), 128'(exp_vld));
            chk("dout", dout, exp_dout);
            chk("drop_count", 128'(drop_count), 128'(0));
        end
        for (int i = 0; i < 4; i++) pops[i] = rdy[i] && (q[i].size() > 0);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            known = 1;
        end else begin
            for (int i = 0; i < 4; i++) if (pops[i]) void'(q[i].pop_front());
            if (v && exp_rdy) q[a].push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1; din = '0; din_valid = 0; addr = '0; dout_ready = '0;
        reset2 = 1; din2 = '0; din_valid2 = 0; addr2 = '0; dout_ready2 = '0;
        @(negedge clk);

        // Reset then idle
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 32'h1234, 0);
        chk("rst_vld", 128'(dout_valid), 128'(0));
        chk("rst_dout", dout, 128'(0));
        cyc(0, 0, 0, 0, 0);
        chk("idle_ready", 128'(din_ready), 128'(1));

        // Single route to channel 3
        cyc(0, 1, 3, 32'hA5A5_0003, 4'b0000);
        chk("route_vld", 128'(dout_valid), 128'(4'b1000));
        chk("route_dout", dout, {32'hA5A5_0003, 96'h0});
        cyc(0, 0, 0, 0, 4'b1000);
        chk("route_popped", 128'(dout_valid), 128'(0));

        // Fill channel 1 and backpressure
        for (int k = 0; k < 4; k++) cyc(0, 1, 1, 32'h10 + k, 4'b0000);
        addr = 1; din_valid = 0; #1;
        chk("full_ch1_ready", 128'(din_ready), 128'(0));
        addr = 2; #1;
        chk("ch2_ready", 128'(din_ready), 128'(1));
        cyc(0, 1, 1, 32'h14, 4'b0000);
        cyc(0, 1, 1, 32'h14, 4'b0000);
        cyc(0, 1, 1, 32'h14, 4'b0010);   // pop while full: still not ready
        cyc(0, 1, 1, 32'h14, 4'b0000);   // accepted now
        for (int k = 1; k <= 4; k++) begin
            chk("fill_order", 128'(dout[63:32]), 128'(32'h10 + k));
            cyc(0, 0, 0, 0, 4'b0010);
        end
        chk("fill_empty", 128'(dout_valid), 128'(0));

        // Concurrent push/pop at occupancy 2 on channel 0
        cyc(0, 1, 0, 32'h100, 0);
        cyc(0, 1, 0, 32'h101, 0);
        for (int k = 0; k < 10; k++) begin
            chk("cc_head", 128'(dout[31:0]), 128'(32'h100 + k));
            cyc(0, 1, 0, 32'h102 + k, 4'b0001);
        end
        cyc(0, 0, 0, 0, 4'b0001);
        chk("cc_last", 128'(dout[31:0]), 128'(32'h10B));
        cyc(0, 0, 0, 0, 4'b0001);
        chk("cc_occ2", 128'(dout_valid), 128'(0));

        // Reset mid-operation
        cyc(0, 1, 0, 32'hC0, 0);
        cyc(0, 1, 2, 32'hC2, 0);
        cyc(0, 1, 2, 32'hC3, 0);
        cyc(1, 0, 0, 0, 0);
        chk("midrst_vld", 128'(dout_valid), 128'(0));
        chk("midrst_drop", 128'(drop_count), 128'(0));
        cyc(0, 1, 2, 32'hBEEF, 0);
        chk("midrst_alone_vld", 128'(dout_valid), 128'(4'b0100));
        chk("midrst_alone_dout", dout, {32'h0, 32'hBEEF, 64'h0});
        cyc(0, 0, 0, 0, 4'b0100);

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            cyc(($urandom_range(99) == 0), ($urandom_range(3) != 0),
                2'($urandom_range(3)), $urandom, 4'($urandom));
        end

        // DUT B: phantom address drop and saturation
        @(posedge clk); @(negedge clk);
        reset2 = 0; addr2 = 3; din_valid2 = 1; din2 = 16'hDEAD;
        chk("b_rst_drop", 128'(drop_count2), 128'(0));
        for (int k = 1; k <= 9; k++) begin
            #1;
            chk("b_oob_ready", 128'(din_ready2), 128'(1));
            @(posedge clk); @(negedge clk);
            chk("b_drop", 128'(drop_count2), 128'((k > 7) ? 7 : k));
            chk("b_no_vld", 128'(dout_valid2), 128'(0));
        end
        addr2 = 1; din2 = 16'h0055;
        @(posedge clk); @(negedge clk);
        chk("b_route_vld", 128'(dout_valid2), 128'(3'b010));
        chk("b_route_dout", 128'(dout2), 128'({16'h0, 16'h0055, 16'h0}));
        din2 = 16'h0066;
        @(posedge clk); @(negedge clk);
        #1;
        chk("b_full_ready", 128'(din_ready2), 128'(0));
        addr2 = 3; #1;
        chk("b_oob_ready_full", 128'(din_ready2), 128'(1));
        din_valid2 = 0;
        reset2 = 1;
        @(posedge clk); @(negedge clk);
        chk("b_rst_clear", 128'({dout_valid2, drop_count2}), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
